// File: rtl/pixel_distributor.sv
// Raster-order coordinate scheduler: hands (x,y) pairs round-robin to a bank of
// pixel engines, skipping busy/full engines, and flags frame completion.
module pixel_distributor #(
  parameter int DATA_WIDTH   = 32,
  parameter int NUM_ENGINES  = 4,
  parameter int ENG_IDX_SIZE = 2,
  parameter int X_SIZE       = 640,
  parameter int Y_SIZE       = 480
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [NUM_ENGINES-1:0]  engine_busy,
  input  logic [NUM_ENGINES-1:0]  full_queue,
  output logic [NUM_ENGINES-1:0]  issue_valid,
  output logic [DATA_WIDTH-1:0]   xpixel_o,
  output logic [DATA_WIDTH-1:0]   ypixel_o,
  output logic [ENG_IDX_SIZE-1:0] grant_idx,
  output logic                    busy,
  output logic                    frame_done
);

  localparam int XW = (X_SIZE > 1) ? $clog2(X_SIZE) : 1;
  localparam int YW = (Y_SIZE > 1) ? $clog2(Y_SIZE) : 1;
  localparam logic [XW-1:0] X_MAX = XW'(X_SIZE - 1);
  localparam logic [YW-1:0] Y_MAX = YW'(Y_SIZE - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e                  state_q, state_d;
  logic [XW-1:0]           x_q, x_d;
  logic [YW-1:0]           y_q, y_d;
  logic [ENG_IDX_SIZE-1:0] ptr_q, ptr_d;
  logic [NUM_ENGINES-1:0]  issue_valid_q, issue_valid_d;
  logic [DATA_WIDTH-1:0]   xpixel_q, xpixel_d;
  logic [DATA_WIDTH-1:0]   ypixel_q, ypixel_d;
  logic [ENG_IDX_SIZE-1:0] grant_idx_q, grant_idx_d;
  logic                    busy_q, busy_d;
  logic                    frame_done_q, frame_done_d;

  logic [NUM_ENGINES-1:0]  eligible;
  logic [NUM_ENGINES-1:0]  rot;
  logic                    found;
  logic [ENG_IDX_SIZE-1:0] win;

  // Search order is rotated so bit 0 of rot is the engine after the pointer;
  // issue_valid_q masks the engine granted last cycle before it raises busy.
  always_comb begin
    eligible = ~engine_busy & ~full_queue & ~issue_valid_q;
    rot      = NUM_ENGINES'({eligible, eligible} >> (32'(ptr_q) + 32'd1));
    found    = 1'b0;
    win      = '0;
    for (int unsigned k = 0; k < NUM_ENGINES; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        win   = ENG_IDX_SIZE'((32'(ptr_q) + 32'd1 + k) % 32'(NUM_ENGINES));
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    ptr_d         = ptr_q;
    issue_valid_d = '0;
    xpixel_d      = xpixel_q;
    ypixel_d      = ypixel_q;
    grant_idx_d   = grant_idx_q;
    busy_d        = busy_q;
    frame_done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        x_d = '0;
        y_d = '0;
        if (start) begin
          state_d = ISSUE;
          busy_d  = 1'b1;
        end
      end
      ISSUE: begin
        if (found) begin
          issue_valid_d = NUM_ENGINES'(1) << win;
          xpixel_d      = DATA_WIDTH'(x_q);
          ypixel_d      = DATA_WIDTH'(y_q);
          grant_idx_d   = win;
          ptr_d         = win;
          if (x_q == X_MAX) begin
            x_d = '0;
            if (y_q == Y_MAX) state_d = DRAIN;
            else              y_d = y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
        end
      end
      DRAIN: begin
        if (engine_busy == '0) state_d = DONE;
      end
      DONE: begin
        frame_done_d = 1'b1;
        busy_d       = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      ptr_q         <= ENG_IDX_SIZE'(NUM_ENGINES - 1);
      issue_valid_q <= '0;
      xpixel_q      <= '0;
      ypixel_q      <= '0;
      grant_idx_q   <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      ptr_q         <= ptr_d;
      issue_valid_q <= issue_valid_d;
      xpixel_q      <= xpixel_d;
      ypixel_q      <= ypixel_d;
      grant_idx_q   <= grant_idx_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign issue_valid = issue_valid_q;
  assign xpixel_o    = xpixel_q;
  assign ypixel_o    = ypixel_q;
  assign grant_idx   = grant_idx_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;

endmodule
